// File: rtl/axi_rd_resp_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_resp_pkg
// Shared constants, FSM state type and a request-legality helper for the
// AXI read-response engine (axi_rd_resp) and its FIFO (axi_rd_fifo).
// No ports: imported with `import axi_rd_resp_pkg::*;`.
// -----------------------------------------------------------------------------
package axi_rd_resp_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_8B     = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Only full-width (8-byte) FIXED and INCR bursts are served from memory;
    // everything else is answered with SLVERR beats.
    function automatic logic burst_unsupported(input logic [2:0] size,
                                               input logic [1:0] burst);
        return (size != SIZE_8B) || (burst == BURST_WRAP) || (burst == BURST_RSVD);
    endfunction

endpackage

// File: rtl/axi_rd_fifo.sv
// -----------------------------------------------------------------------------
// axi_rd_fifo
// Small synchronous FIFO with occupancy count. A push while full is accepted
// only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_din     write strobe and data
//   i_pop             read strobe (head advances on the next edge)
//   o_dout            head entry (stable until popped)
//   o_count           number of stored entries
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module axi_rd_fifo
    import axi_rd_resp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_din,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_dout,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi_rd_resp.sv
// -----------------------------------------------------------------------------
// axi_rd_resp
// AXI read-channel responder in front of a 1-cycle-latency SRAM. AR requests
// are queued (2 deep), a burst FSM turns each into word reads (or SLVERR beats
// for unsupported size/burst), and returning beats are buffered (2 deep) and
// presented on the R channel in order.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ARID/ARADDR/ARLEN/ARSIZE/
//   ARBURST/ARREGION/ARVALID,ARREADY AXI read-address channel (ARREGION unused)
//   RID/RDATA/RRESP/RLAST/RVALID,
//   RREADY                           AXI read-data channel
//   mem_rd_en, mem_rd_addr           SRAM read strobe and word address
//   mem_rd_data                      SRAM data, valid 1 cycle after mem_rd_en
//   busy                             any request queued or beat pending
// -----------------------------------------------------------------------------
module axi_rd_resp
    import axi_rd_resp_pkg::*;
#(
    parameter int ARID_WIDTH   = 4,
    parameter int ARADDR_WIDTH = 10,
    parameter int RDATA_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ARID_WIDTH-1:0]   ARID,
    input  logic [ARADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [3:0]              ARREGION,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ARID_WIDTH-1:0]   RID,
    output logic [RDATA_WIDTH-1:0]  RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    mem_rd_en,
    output logic [ARADDR_WIDTH-4:0] mem_rd_addr,
    input  logic [RDATA_WIDTH-1:0]  mem_rd_data,
    output logic                    busy
);

    localparam int WA    = ARADDR_WIDTH - 3;
    localparam int REQ_W = ARID_WIDTH + WA + 8 + 3 + 2;
    localparam int RF_W  = ARID_WIDTH + RDATA_WIDTH + 2 + 1;

    // request FIFO
    logic [REQ_W-1:0]      w_req_din;
    logic [REQ_W-1:0]      w_req_dout;
    logic                  w_req_push;
    logic                  w_req_pop;
    logic [1:0]            w_req_count;
    logic                  w_req_full;
    logic                  w_req_empty;
    logic [ARID_WIDTH-1:0] w_hd_id;
    logic [WA-1:0]         w_hd_waddr;
    logic [7:0]            w_hd_len;
    logic [2:0]            w_hd_size;
    logic [1:0]            w_hd_burst;

    // burst FSM and context
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ARID_WIDTH-1:0] r_id;
    logic [WA-1:0]         r_waddr;
    logic [8:0]            r_beats;
    logic                  r_fixed;
    logic                  w_issue;
    logic                  w_credit;
    logic [2:0]            w_occ;

    // memory-return stage
    logic                   r_vld_p1;
    logic [ARID_WIDTH-1:0]  r_id_p1;
    logic                   r_last_p1;
    logic                   r_err_p1;
    logic [RDATA_WIDTH-1:0] w_rdata_p1;

    // R FIFO
    logic [RF_W-1:0]       w_rf_din;
    logic [RF_W-1:0]       w_rf_dout;
    logic [1:0]            w_rf_count;
    logic                  w_rf_full;
    logic                  w_rf_empty;
    logic                  w_rf_pop;

    logic                  w_unused;

    assign w_unused = ^{ARREGION, ARADDR[2:0], w_req_count, w_rf_full};

    // ---------------------------------------------------------------- AR queue
    assign ARREADY    = rst_n & ~w_req_full;
    assign w_req_push = ARVALID & ARREADY;
    assign w_req_din  = {ARID, ARADDR[ARADDR_WIDTH-1:3], ARLEN, ARSIZE, ARBURST};
    assign {w_hd_id, w_hd_waddr, w_hd_len, w_hd_size, w_hd_burst} = w_req_dout;

    axi_rd_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (2)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_push),
        .i_din   (w_req_din),
        .i_pop   (w_req_pop),
        .o_dout  (w_req_dout),
        .o_count (w_req_count),
        .o_full  (w_req_full),
        .o_empty (w_req_empty)
    );

    // ------------------------------------------------------------ burst issue
    // Occupancy the R FIFO will see when a beat issued now lands: entries
    // already buffered, plus the beat in the return stage, minus the pop
    // happening this cycle. Counting the pop is what sustains 1 beat/cycle.
    assign w_occ    = {1'b0, w_rf_count} + {2'b00, r_vld_p1} - {2'b00, w_rf_pop};
    assign w_credit = (w_occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_pop   = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_req_empty) begin
                    w_req_pop   = 1'b1;
                    w_state_nxt = burst_unsupported(w_hd_size, w_hd_burst) ? ST_ERR : ST_BURST;
                end
            end
            ST_BURST, ST_ERR: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_beats == 9'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_waddr <= '0;
            r_beats <= '0;
            r_fixed <= 1'b0;
        end else if (w_req_pop) begin
            r_id    <= w_hd_id;
            r_waddr <= w_hd_waddr;
            r_beats <= {1'b0, w_hd_len} + 9'd1;
            r_fixed <= (w_hd_burst == BURST_FIXED);
        end else if (w_issue) begin
            r_beats <= r_beats - 9'd1;
            // INCR wraps naturally at the top of the word space
            if (!r_fixed) begin
                r_waddr <= r_waddr + WA'(1);
            end
        end
    end

    // Error bursts consume credit and produce beats but never touch memory
    assign mem_rd_en   = w_issue & (r_state == ST_BURST);
    assign mem_rd_addr = r_waddr;

    // ------------------------------------------------- stage p1: memory return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        r_id_p1   <= r_id;
        r_last_p1 <= (r_beats == 9'd1);
        r_err_p1  <= (r_state == ST_ERR);
    end

    assign w_rdata_p1 = r_err_p1 ? '0 : mem_rd_data;
    assign w_rf_din   = {r_id_p1, w_rdata_p1, (r_err_p1 ? RESP_SLVERR : RESP_OKAY), r_last_p1};

    // ------------------------------------------------------- stage p2: R FIFO
    assign w_rf_pop = RVALID & RREADY;

    axi_rd_fifo #(
        .WIDTH (RF_W),
        .DEPTH (2)
    ) u_r_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_vld_p1),
        .i_din   (w_rf_din),
        .i_pop   (w_rf_pop),
        .o_dout  (w_rf_dout),
        .o_count (w_rf_count),
        .o_full  (w_rf_full),
        .o_empty (w_rf_empty)
    );

    assign {RID, RDATA, RRESP, RLAST} = w_rf_dout;
    assign RVALID = ~w_rf_empty;

    assign busy = ~w_req_empty | (r_state != ST_IDLE) | r_vld_p1 | ~w_rf_empty;

endmodule
